// File: rtl/audio_pkg.sv
// Shared audio definitions: FSM state encoding and the codec sample width,
// reused by the codec-side blocks.
package audio_pkg;

  localparam int AUDIO_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    PUSH = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tone_phase_gen.sv
// Square-wave phase tracker: counts samples within a half period and flips
// polarity each time a half period completes. Polarity starts high.
module tone_phase_gen #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                advance,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] half_period,
  output logic                polarity
);

  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic                pol_q, pol_d;

  // Next phase/polarity: clear wins, otherwise step once per accepted sample.
  always_comb begin
    phase_d = phase_q;
    pol_d   = pol_q;
    if (clear) begin
      phase_d = '0;
      pol_d   = 1'b1;
    end else if (advance) begin
      if (phase_q == half_period - PERIOD_W'(1)) begin
        phase_d = '0;
        pol_d   = ~pol_q;
      end else begin
        phase_d = phase_q + PERIOD_W'(1);
      end
    end
  end

  // Phase and polarity registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      pol_q   <= 1'b1;
    end else begin
      phase_q <= phase_d;
      pol_q   <= pol_d;
    end
  end

  assign polarity = pol_q;

endmodule

// File: rtl/audio_tone_writer.sv
// Square-wave test-tone generator feeding the codec write port, identical
// sample on both channels; one-shot bursts of N samples or continuous play.
// Optional macro SAMPLE_COUNT_EN adds a free-running 32-bit count of accepted
// samples on output sample_count.
module audio_tone_writer
  import audio_pkg::*;
#(
  parameter int DATA_W   = AUDIO_DATA_W,
  parameter int PERIOD_W = 16,
  parameter int DUR_W    = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] half_period,
  input  logic [DATA_W-2:0]   amplitude,
  input  logic [DUR_W-1:0]    duration,
  input  logic                write_ready,
  output logic                write,
  output logic [DATA_W-1:0]   writedata_left,
  output logic [DATA_W-1:0]   writedata_right,
  output logic                busy,
  output logic                done
`ifdef SAMPLE_COUNT_EN
  ,
  output logic [31:0]         sample_count
`endif
);

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] hp_q, hp_d;
  logic [DATA_W-2:0]   amp_q, amp_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic                stop_seen_q, stop_seen_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;

  logic                accept;
  logic                polarity;
  logic                clear;
  logic                advance;
  logic [DUR_W-1:0]    cnt_inc;
  logic [DATA_W-1:0]   pos_sample;
  logic [DATA_W-1:0]   neg_sample;

  assign accept     = write_q & write_ready;
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + DUR_W'(1);
  assign pos_sample = {1'b0, amp_q};
  assign neg_sample = '0 - pos_sample;

  tone_phase_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_phase (
    .clk         (CLOCK_50),
    .rst_n       (reset_n),
    .advance     (advance),
    .clear       (clear),
    .half_period (hp_q),
    .polarity    (polarity)
  );

  // FSM next-state, handshake and sample datapath.
  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    amp_d       = amp_q;
    dur_d       = dur_q;
    cnt_d       = cnt_q;
    stop_seen_d = stop_seen_q;
    write_d     = write_q;
    data_d      = data_q;
    done_d      = 1'b0;
    clear       = 1'b0;
    advance     = 1'b0;
    case (state_q)
      IDLE: begin
        write_d = 1'b0;
        if (start && !stop) begin
          hp_d        = half_period;
          amp_d       = amplitude;
          dur_d       = duration;
          cnt_d       = '0;
          stop_seen_d = 1'b0;
          clear       = 1'b1;
          state_d     = PREP;
        end
      end
      PREP: begin
        stop_seen_d = 1'b0;
        if (stop) begin
          write_d = 1'b0;
          state_d = IDLE;
        end else begin
          if (hp_q == '0) data_d = '0;
          else            data_d = polarity ? pos_sample : neg_sample;
          write_d = 1'b1;
          state_d = PUSH;
        end
      end
      PUSH: begin
        // A stop here is only remembered; the presented sample stays put.
        if (stop) stop_seen_d = 1'b1;
        if (accept) begin
          write_d = 1'b0;
          cnt_d   = cnt_inc;
          advance = 1'b1;
          if (dur_q != '0 && cnt_inc == dur_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else if (stop_seen_q || stop) begin
            state_d = IDLE;
          end else begin
            state_d = PREP;
          end
        end
      end
      DONE: begin
        write_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hp_q        <= '0;
      amp_q       <= '0;
      dur_q       <= '0;
      cnt_q       <= '0;
      stop_seen_q <= 1'b0;
      write_q     <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      amp_q       <= amp_d;
      dur_q       <= dur_d;
      cnt_q       <= cnt_d;
      stop_seen_q <= stop_seen_d;
      write_q     <= write_d;
      data_q      <= data_d;
      done_q      <= done_d;
    end
  end

  assign write           = write_q;
  assign writedata_left  = data_q;
  assign writedata_right = data_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;

`ifdef SAMPLE_COUNT_EN
  logic [31:0] sc_q, sc_d;

  assign sc_d = sc_q + 32'(accept);

  // Lifetime count of accepted samples, wraps modulo 2^32.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) sc_q <= '0;
    else          sc_q <= sc_d;
  end

  assign sample_count = sc_q;
`endif

endmodule

// File: tb/tb_audio_tone_writer.sv
// Self-checking bench for audio_tone_writer: table of bursts plus directed
// sequences for stall, stop, async reset and start/stop collisions.
module tb_audio_tone_writer;

  localparam int DW = 24;
  localparam int PW = 16;
  localparam int UW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic [PW-1:0] half_period;
  logic [DW-2:0] amplitude;
  logic [UW-1:0] duration;
  logic          write_ready;
  logic          write;
  logic [DW-1:0] writedata_left;
  logic [DW-1:0] writedata_right;
  logic          busy;
  logic          done;
`ifdef SAMPLE_COUNT_EN
  logic [31:0]   sample_count;
`endif

  always #5 clk = ~clk;

  audio_tone_writer #(
    .DATA_W   (DW),
    .PERIOD_W (PW),
    .DUR_W    (UW)
  ) dut (
    .CLOCK_50        (clk),
    .reset_n         (reset_n),
    .start           (start),
    .stop            (stop),
    .half_period     (half_period),
    .amplitude       (amplitude),
    .duration        (duration),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .busy            (busy),
    .done            (done)
`ifdef SAMPLE_COUNT_EN
    ,
    .sample_count    (sample_count)
`endif
  );

  typedef struct packed {
    logic [PW-1:0]        hp;
    logic [DW-2:0]        amp;
    logic [UW-1:0]        dur;
    logic [0:7][DW-1:0]   exp;
  } vec_t;

  vec_t          tbl [5];
  logic [DW-1:0] exp_s [16];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present burst parameters and pulse start for one cycle; returns in PREP.
  task automatic launch(input logic [PW-1:0] hp, input logic [DW-2:0] amp, input logic [UW-1:0] dur);
    half_period = hp;
    amplitude   = amp;
    duration    = dur;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Record accepted samples exp_s[first..last-1]; returns on the cycle after the last one.
  task automatic collect(input string tag, input int first, input int last);
    int i;
    int budget;
    i = first;
    budget = 0;
    while (i < last && budget < 400) begin
      if (write && write_ready) begin
        chk($sformatf("%s left[%0d]", tag, i), 32'(writedata_left), 32'(exp_s[i]));
        chk($sformatf("%s right[%0d]", tag, i), 32'(writedata_right), 32'(exp_s[i]));
        i++;
      end
      tick();
      budget++;
    end
    if (i < last) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d samples expected %0d", tag, i - first, last - first);
    end
  endtask

  task automatic wait_write(input string tag);
    int n;
    n = 0;
    while (!write && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("%s write rises", tag), 32'(write), 32'd1);
  endtask

  task automatic check_done(input string tag);
    chk($sformatf("%s done pulse", tag), 32'(done), 32'd1);
    chk($sformatf("%s busy in DONE", tag), 32'(busy), 32'd1);
    tick();
    chk($sformatf("%s done drop", tag), 32'(done), 32'd0);
    chk($sformatf("%s busy drop", tag), 32'(busy), 32'd0);
    chk($sformatf("%s write idle", tag), 32'(write), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0].hp = 16'd2; tbl[0].amp = 23'h000100; tbl[0].dur = 16'd6;
    tbl[0].exp = {24'h000100, 24'h000100, 24'hFFFF00, 24'hFFFF00,
                  24'h000100, 24'h000100, 24'h0, 24'h0};
    tbl[1].hp = 16'd0; tbl[1].amp = 23'h7FFFFF; tbl[1].dur = 16'd3;
    tbl[1].exp = {24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    tbl[2].hp = 16'd1; tbl[2].amp = 23'h7FFFFF; tbl[2].dur = 16'd4;
    tbl[2].exp = {24'h7FFFFF, 24'h800001, 24'h7FFFFF, 24'h800001,
                  24'h0, 24'h0, 24'h0, 24'h0};
    tbl[3].hp = 16'd3; tbl[3].amp = 23'h000010; tbl[3].dur = 16'd1;
    tbl[3].exp = {24'h000010, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    tbl[4].hp = 16'd3; tbl[4].amp = 23'h000010; tbl[4].dur = 16'd5;
    tbl[4].exp = {24'h000010, 24'h000010, 24'h000010, 24'hFFFFF0,
                  24'hFFFFF0, 24'h0, 24'h0, 24'h0};

    reset_n     = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    half_period = '0;
    amplitude   = '0;
    duration    = '0;
    write_ready = 1'b1;
    tick();
    tick();
    chk("reset write", 32'(write), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset data", 32'(writedata_left), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post-reset busy", 32'(busy), 32'd0);

    // Table-driven bursts with write_ready held high.
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 8; j++) exp_s[j] = tbl[k].exp[j];
      launch(tbl[k].hp, tbl[k].amp, tbl[k].dur);
      chk($sformatf("vec%0d busy in PREP", k), 32'(busy), 32'd1);
      chk($sformatf("vec%0d write in PREP", k), 32'(write), 32'd0);
      tick();
      chk($sformatf("vec%0d first write latency", k), 32'(write), 32'd1);
      collect($sformatf("vec%0d", k), 0, int'(tbl[k].dur));
      check_done($sformatf("vec%0d", k));
    end

    // Stall for 10 cycles on the third sample of a 6-sample burst.
    for (int j = 0; j < 8; j++) exp_s[j] = tbl[0].exp[j];
    launch(16'd2, 23'h000100, 16'd6);
    collect("stall pre", 0, 2);
    write_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("stall write c%0d", c), 32'(write), 32'd1);
      chk($sformatf("stall data c%0d", c), 32'(writedata_left), 32'hFFFF00);
    end
    write_ready = 1'b1;
    collect("stall post", 2, 6);
    check_done("stall");

    // Continuous tone, stop while the sample is held off by the codec.
    write_ready = 1'b0;
    launch(16'd2, 23'h000100, 16'd0);
    wait_write("stop");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stop hold write c%0d", c), 32'(write), 32'd1);
      chk($sformatf("stop hold data c%0d", c), 32'(writedata_left), 32'h000100);
      tick();
    end
    write_ready = 1'b1;
    tick();
    chk("stop idle busy", 32'(busy), 32'd0);
    chk("stop idle write", 32'(write), 32'd0);
    chk("stop no done", 32'(done), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("stop no further write c%0d", c), 32'(write), 32'd0);
    end

    // Asynchronous reset while a sample is being pushed.
    write_ready = 1'b0;
    launch(16'd2, 23'h000100, 16'd0);
    wait_write("areset");
    #2 reset_n = 1'b0;
    #1;
    chk("areset write", 32'(write), 32'd0);
    chk("areset busy", 32'(busy), 32'd0);
    chk("areset done", 32'(done), 32'd0);
    chk("areset data", 32'(writedata_left), 32'd0);
    tick();
    reset_n = 1'b1;
    write_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("areset stays idle c%0d", c), 32'(busy | write), 32'd0);
    end

    // start+stop together in IDLE does nothing.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("start+stop busy", 32'(busy), 32'd0);
    tick();
    chk("start+stop write", 32'(write | busy), 32'd0);

    // Restart while busy must not relatch half_period.
    exp_s[0] = 24'h000100; exp_s[1] = 24'hFFFF00;
    exp_s[2] = 24'h000100; exp_s[3] = 24'hFFFF00;
    launch(16'd1, 23'h000100, 16'd4);
    collect("busy start pre", 0, 1);
    half_period = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect("busy start post", 1, 4);
    check_done("busy start");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_tone_writer.md
Name: audio_tone_writer

Overview:
Write-side companion to the codec read path. Generates a square-wave test tone and pushes it into the audio codec's write port (write / write_ready / writedata_left / writedata_right), with an identical sample on both channels. Sits beside the codec instance in the top level and is driven by front-panel controls or a sequencer. It supports one-shot bursts of N samples or continuous play.

Parameters:
DATA_W, 24, sample width in bits (two's complement) to match the codec.
PERIOD_W, 16, width of the half-period count in samples.
DUR_W, 16, width of the burst duration count in samples.

Ports:
CLOCK_50  in  1  system clock; all logic is on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  single-cycle pulse that launches a tone.
stop  in  1  single-cycle pulse that aborts a tone.
half_period  in  PERIOD_W  samples per half cycle; latched at start.
amplitude  in  DATA_W-1  unsigned magnitude; latched at start.
duration  in  DUR_W  samples to emit; 0 means continuous. Latched at start.
write_ready  in  1  codec FIFO has space.
write  out  1  sample valid, presented to the codec.
writedata_left  out  DATA_W  left sample.
writedata_right  out  DATA_W  right sample; always equals writedata_left.
busy  out  1  high while not in IDLE.
done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: write=0, writedata_*=0, busy=0, done=0.
  - Internal: state=IDLE, phase count=0, polarity=1, sample count=0.
- Handshake: a sample is accepted on any cycle where write=1 and write_ready=1. After acceptance, write drops the next cycle. Data is held stable while write=1.
- States:
  - IDLE: on start with stop=0, latch the inputs, clear counters, set polarity=1, go to PREP. start and stop together leave the block in IDLE. stop alone does nothing.
  - PREP (1 cycle): compute the sample and register it onto writedata_*.
    - half_period=0: sample is 0 (silence).
    - Otherwise polarity=1 gives +{0,amp}, polarity=0 gives its two's-complement negative.
    - Then set write=1 and go to PUSH.
    - If stop is seen in PREP: go to IDLE with write=0.
  - PUSH: hold write=1 until write_ready=1. On acceptance:
    - Increment the sample count.
    - Advance the phase: if phase==half_period-1, set phase=0 and toggle polarity; otherwise phase+1.
    - If duration!=0 and the new count==duration: go to DONE.
    - Else if stop was seen in PUSH: go to IDLE.
    - Otherwise go to PREP.
    - stop during PUSH is remembered. The in-flight sample is never withdrawn.
  - DONE (1 cycle): done=1, write=0, go to IDLE.
- Throughput: at most one sample per 2 clocks. Latency from start to the first write=1 is 2 cycles.
- Wrap-around:
  - Phase and sample counters never overflow in continuous mode: the phase wraps per period, and the sample count saturates at all-ones.
  - With duration=1, exactly one sample is emitted.
- busy = (state != IDLE). A start while busy is ignored.

Optional Feature:
SAMPLE_COUNT_EN:
- Defined: adds an output sample_count[31:0] giving the total samples accepted since reset. It wraps modulo 2^32, is unaffected by start/stop, and resets to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package (audio_pkg): state enum (IDLE, PREP, PUSH, DONE) and localparam AUDIO_DATA_W=24, reused by codec-side blocks.
- One sub-module, tone_phase_gen: holds the phase counter and polarity, with inputs advance, clear and half_period, and output polarity. The FSM and data path stay in audio_tone_writer.

Test Plan:
1. half_period=2, amplitude=0x000100, duration=6, write_ready=1 → samples 0x000100, 0x000100, 0xFFFF00, 0xFFFF00, 0x000100, 0x000100. done pulses once, 1 cycle after the 6th acceptance. busy falls with done.
2. write_ready held low for 10 cycles mid-burst → write stays 1 and data stays stable for all 10 cycles. The sample is accepted exactly once when write_ready rises. No sample is skipped or duplicated.
3. duration=0, stop pulsed in PUSH while write_ready=0 → the sample is held, accepted when write_ready=1, then the FSM goes to IDLE. No further write.
4. half_period=0, amplitude=0x7FFFFF, duration=3 → three samples of 0x000000, then done.
5. reset_n dropped while write=1 in PUSH → write, busy, done and data go to 0 immediately (asynchronously). After release, the block stays idle until the next start.
6. start and stop pulsed on the same cycle in IDLE → busy stays 0 and no write occurs. A start issued while busy leaves the latched half_period unchanged (checked via the output waveform).
